ddr3_req_arb: RTL



---
 rtl/ddr3_req_arb.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_req_arb.sv
// -----------------------------------------------------------------------------
// ddr3_req_arb
//
// Shares the DDR3 core native RAM port between two requesters, for example an
// AXI-to-RAM bridge on port 0 and a DMA/refill engine on port 1.
//
// Request path:
//   A request is pending on a port while its wr or rd strobe is high. A port is
//   eligible while it is pending and has fewer than MAX_OUTSTANDING requests
//   accepted by the core but not yet acknowledged. From IDLE the arbiter
//   registers a grant and moves to GNT. In GNT the granted port's request
//   fields are driven straight through to the core until outport_accept_i,
//   which pulses that port's accept and returns the FSM to IDLE. Each request
//   therefore occupies at least two cycles. Ownership is stamped into bit 15 of
//   the request id sent to the core.
//
// Response path:
//   outport_ack_i is routed combinationally to the port named by resp_id[15].
//   Bit 15 is cleared on the way back. Both ports see the core's read data and
//   error; only the acked port's values are meaningful.
//
// Outstanding tracking:
//   Each port has a counter that increments on accept and decrements on ack.
//   An ack that arrives for a port whose counter is zero is still forwarded.
//   The counter stays at zero and the sticky orphan_ack_o flag is raised.
//
// Configuration:
//   DDR3_ARB_FIXED_PRIO_EN  when defined, port 0 always wins when eligible
//                           (port 1 may starve). When undefined, arbitration
//                           is round-robin, using a last-grant register that
//                           resets to 1 so port 0 wins the first tie.
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-unacked requests allowed per port (1..15)
//   CNT_W            width of each outstanding counter
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   inportN_*_i             request from port N (wr, wr_mask, rd, addr,
//                           write_data, req_id; req_id[15] must be 0)
//   inportN_accept_o        request taken this cycle
//   inportN_ack_o/error_o/read_data_o/resp_id_o
//                           response for port N (resp_id[15] forced to 0)
//   outport_*_o             request to core
//   outport_accept_i        core accepted the request
//   outport_ack_i/error_i/read_data_i/resp_id_i
//                           response from core
//   orphan_ack_o            sticky: ack seen for a port with nothing
//                           outstanding
// -----------------------------------------------------------------------------
module ddr3_req_arb #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         inport0_wr_i,
  input  logic [15:0]  inport0_wr_mask_i,
  input  logic         inport0_rd_i,
  input  logic [31:0]  inport0_addr_i,
  input  logic [127:0] inport0_write_data_i,
  input  logic [15:0]  inport0_req_id_i,
  output logic         inport0_accept_o,
  output logic         inport0_ack_o,
  output logic         inport0_error_o,
  output logic [127:0] inport0_read_data_o,
  output logic [15:0]  inport0_resp_id_o,

  input  logic         inport1_wr_i,
  input  logic [15:0]  inport1_wr_mask_i,
  input  logic         inport1_rd_i,
  input  logic [31:0]  inport1_addr_i,
  input  logic [127:0] inport1_write_data_i,
  input  logic [15:0]  inport1_req_id_i,
  output logic         inport1_accept_o,
  output logic         inport1_ack_o,
  output logic         inport1_error_o,
  output logic [127:0] inport1_read_data_o,
  output logic [15:0]  inport1_resp_id_o,

  output logic         outport_wr_o,
  output logic [15:0]  outport_wr_mask_o,
  output logic         outport_rd_o,
  output logic [31:0]  outport_addr_o,
  output logic [127:0] outport_write_data_o,
  output logic [15:0]  outport_req_id_o,
  input  logic         outport_accept_i,
  input  logic         outport_ack_i,
  input  logic         outport_error_i,
  input  logic [127:0] outport_read_data_i,
  input  logic [15:0]  outport_resp_id_i,

  output logic         orphan_ack_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GNT  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;     // port that owns the current grant
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             orphan_q, orphan_d;
`ifndef DDR3_ARB_FIXED_PRIO_EN
  logic             last_grant_q, last_grant_d;
`endif

  logic pend0, pend1;
  logic elig0, elig1;
  logic pick;
  logic gnt_active;
  logic acc0, acc1;
  logic ack0, ack1;

  // Requesters are required to keep req_id[15] low; ownership is re-stamped
  // here, so the incoming bit is ignored.
  logic unused_id_msb;
  assign unused_id_msb = inport0_req_id_i[15] ^ inport1_req_id_i[15];

  // Outstanding counter update. Accept and ack together cancel. An ack with
  // nothing outstanding saturates at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  // Eligibility and winner selection
  always_comb begin
    pend0 = inport0_wr_i | inport0_rd_i;
    pend1 = inport1_wr_i | inport1_rd_i;
    elig0 = pend0 && (cnt0_q < MAX_CNT);
    elig1 = pend1 && (cnt1_q < MAX_CNT);
`ifdef DDR3_ARB_FIXED_PRIO_EN
    pick  = ~elig0;
`else
    // On a tie the port that did not win last time goes next; otherwise the
    // single eligible port wins.
    if (elig0 && elig1) begin
      pick = ~last_grant_q;
    end else begin
      pick = elig1;
    end
`endif
  end

  // FSM next state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
`ifndef DDR3_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (elig0 || elig1) begin
          state_d      = ST_GNT;
          grant_d      = pick;
`ifndef DDR3_ARB_FIXED_PRIO_EN
          last_grant_d = pick;
`endif
        end
      end
      ST_GNT: begin
        if (outport_accept_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request forwarding, accept pulses and response routing
  always_comb begin
    gnt_active = (state_q == ST_GNT);

    // Field mux always follows the registered grant; only the strobes are
    // qualified, so the other fields are don't-care outside GNT.
    outport_wr_o         = gnt_active & (grant_q ? inport1_wr_i : inport0_wr_i);
    outport_rd_o         = gnt_active & (grant_q ? inport1_rd_i : inport0_rd_i);
    outport_wr_mask_o    = grant_q ? inport1_wr_mask_i    : inport0_wr_mask_i;
    outport_addr_o       = grant_q ? inport1_addr_i       : inport0_addr_i;
    outport_write_data_o = grant_q ? inport1_write_data_i : inport0_write_data_i;
    outport_req_id_o     = {grant_q,
                            grant_q ? inport1_req_id_i[14:0] : inport0_req_id_i[14:0]};

    acc0 = gnt_active & outport_accept_i & ~grant_q;
    acc1 = gnt_active & outport_accept_i &  grant_q;

    ack0 = outport_ack_i & ~outport_resp_id_i[15];
    ack1 = outport_ack_i &  outport_resp_id_i[15];
  end

  assign inport0_accept_o    = acc0;
  assign inport1_accept_o    = acc1;

  assign inport0_ack_o       = ack0;
  assign inport0_error_o     = outport_error_i;
  assign inport0_read_data_o = outport_read_data_i;
  assign inport0_resp_id_o   = {1'b0, outport_resp_id_i[14:0]};

  assign inport1_ack_o       = ack1;
  assign inport1_error_o     = outport_error_i;
  assign inport1_read_data_o = outport_read_data_i;
  assign inport1_resp_id_o   = {1'b0, outport_resp_id_i[14:0]};

  // Outstanding counters and orphan detection
  always_comb begin
    cnt0_d   = cnt_next(cnt0_q, acc0, ack0);
    cnt1_d   = cnt_next(cnt1_q, acc1, ack1);
    orphan_d = orphan_q
             | (ack0 & (cnt0_q == '0))
             | (ack1 & (cnt1_q == '0));
  end

  assign orphan_ack_o = orphan_q;

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      orphan_q     <= 1'b0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      orphan_q     <= orphan_d;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
